gpio_slave: RTL and testbench
=============================

// Module: gpio_slave
// PURPOSE
//  Memory-mapped GPIO responder in the 4KB window at 0xFFFF_2000, selected by cs_gpio from the address decoder.
//  - Holds output, direction and interrupt-enable registers.
//  - Double-synchronises pad inputs and latches rising edges as interrupt status.
//  - Drives one level interrupt line to the core.
// PARAMETERS
//  GPIO_W   32  number of GPIO pins (1..32); register bits above GPIO_W-1 read 0
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  reset_n    in   1       synchronous reset, active low
//  cs         in   1       chip select (cs_gpio from decoder), qualifies access this cycle
//  we         in   1       1=write, 0=read; valid when cs=1
//  be         in   4       byte enables for writes; ignored for reads
//  addr       in   12      byte offset in window; addr[1:0] ignored
//  wdata      in   32      write data
//  rdata      out  32      read data, valid when rvalid=1
//  rvalid     out  1       one-cycle pulse, read data ready
//  gpio_in    in   GPIO_W  asynchronous pad inputs
//  gpio_out   out  GPIO_W  output register value
//  gpio_oe    out  GPIO_W  output enable, 1=drive pin (=DIR register)
//  irq        out  1       |(IRQ_STAT & IRQ_EN), registered
// BEHAVIOUR
//  Register map, word offsets; unmapped offsets read 0 and ignore writes:
//   0x000 OUT  RW
//   0x004 DIR  RW
//   0x008 IN   RO, synchronised input, writes ignored
//   0x00C IEN  RW
//   0x010 STAT W1C, write 1 clears a bit, write 0 has no effect
//  Reset (reset_n=0 at clk edge):
//   - OUT, DIR, IEN, STAT, sync stages, rdata, rvalid, irq all 0.
//   - Any access in flight is dropped; rvalid stays 0.
//  Writes:
//   - cs=1, we=1 updates the selected register at that clk edge.
//   - Only bytes with be[i]=1 are affected; bits >= GPIO_W are discarded.
//   - Writes produce no rvalid.
//  Reads:
//   - cs=1, we=0 in cycle N gives rdata and rvalid=1 in cycle N+1.
//   - rdata holds its value until the next read; rvalid is a single-cycle pulse.
//   - Back-to-back reads give back-to-back rvalid.
//   - A read in the same cycle as a write to the same register returns the pre-write value.
//  Input path:
//   - s1 <= gpio_in; s2 <= s1; s3 <= s2.
//   - IN reads s2 (2-cycle latency).
//   - Rising edge = s2 & ~s3, which sets the STAT bit at the next edge.
//   - All stages reset to 0, so an input high at reset release gives one edge.
//  Simultaneous events: a set in STAT wins over a W1C clear of the same bit in the same cycle, so no edge is lost.
//  STAT bits set regardless of IEN; IEN gates only irq.
//  irq is registered: it asserts 1 cycle after STAT&IEN becomes non-zero and drops 1 cycle after clear.
//  Pin function is independent of direction: gpio_out reflects OUT even when DIR=0.
// TESTING
//  1. Reset with reset_n=0 for 2 cycles -> all outputs 0; read 0x000..0x010 -> all 0x0.
//  2. Write OUT=0xA5A5_5A5A with be=4'b0011 -> read OUT=0x0000_5A5A; write be=4'b1100 -> OUT=0xA5A5_5A5A.
//  3. gpio_in 0->0x1 -> IN reads 0x1 no earlier than 2 cycles later; STAT=0x1; with IEN=0x1, irq=1.
//  4. Write STAT=0x1 in the same cycle a new edge on bit0 arrives -> STAT bit0 stays 1 and irq stays 1.
//  5. Read 0x008 in cycle N -> rvalid=1 only in N+1; read 0x014 -> rdata=0x0; write 0x008 -> IN unchanged.
//  6. Assert reset_n=0 in the cycle after a read request -> rvalid=0 and OUT/DIR/IEN/STAT=0.

Source files
------------

// File: rtl/gpio_slave.sv
// Memory-mapped GPIO responder: OUT/DIR/IEN registers, synchronised inputs,
// rising-edge interrupt status (W1C) and a registered level interrupt.
module gpio_slave #(
    parameter int GPIO_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [11:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [9:0] A_OUT  = 10'd0;
    localparam logic [9:0] A_DIR  = 10'd1;
    localparam logic [9:0] A_IN   = 10'd2;
    localparam logic [9:0] A_IEN  = 10'd3;
    localparam logic [9:0] A_STAT = 10'd4;

    logic [GPIO_W-1:0] out_r;
    logic [GPIO_W-1:0] dir_r;
    logic [GPIO_W-1:0] ien_r;
    logic [GPIO_W-1:0] stat_r;
    logic [GPIO_W-1:0] s1;
    logic [GPIO_W-1:0] s2;
    logic [GPIO_W-1:0] s3;

    logic [9:0]        word;
    logic              wr;
    logic              rd;
    logic [31:0]       bmask;
    logic [GPIO_W-1:0] wmask;
    logic [GPIO_W-1:0] wbits;
    logic [GPIO_W-1:0] rise;
    logic [GPIO_W-1:0] clr;
    logic [31:0]       rmux;
    logic              unused;

    assign word  = addr[11:2];
    assign wr    = cs & we;
    assign rd    = cs & ~we;
    assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wmask = bmask[GPIO_W-1:0];
    assign wbits = wdata[GPIO_W-1:0];
    assign rise  = s2 & ~s3;
    assign clr   = (wr && word == A_STAT) ? (wbits & wmask) : '0;

    assign unused = ^{addr[1:0], wdata};

    function automatic logic [GPIO_W-1:0] merge(
        input logic [GPIO_W-1:0] old
    );
        merge = (old & ~wmask) | (wbits & wmask);
    endfunction

    function automatic logic [31:0] zx(input logic [GPIO_W-1:0] v);
        zx = '0;
        zx[GPIO_W-1:0] = v;
    endfunction

    // Read mux sees the pre-write register values of the same cycle.
    always_comb begin
        rmux = '0;
        case (word)
            A_OUT:   rmux = zx(out_r);
            A_DIR:   rmux = zx(dir_r);
            A_IN:    rmux = zx(s2);
            A_IEN:   rmux = zx(ien_r);
            A_STAT:  rmux = zx(stat_r);
            default: rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_r <= '0;
            dir_r <= '0;
            ien_r <= '0;
        end else if (wr) begin
            if (word == A_OUT) out_r <= merge(out_r);
            if (word == A_DIR) dir_r <= merge(dir_r);
            if (word == A_IEN) ien_r <= merge(ien_r);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A new edge overrides a clear of the same bit so no event is lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_r <= '0;
        end else begin
            stat_r <= (stat_r & ~clr) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) rdata <= rmux;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(stat_r & ien_r);
        end
    end

    assign gpio_out = out_r;
    assign gpio_oe  = dir_r;

endmodule

// File: tb/tb_gpio_slave.sv
// Directed bench for gpio_slave; read results checked against a
// scoreboard of expected values queued when each read is issued.
module tb_gpio_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    gpio_slave #(.GPIO_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        tick();
        cs = 1'b0; we = 1'b0;
        chk("wr_no_rvalid", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] exp);
        logic [31:0] e;
        cs = 1'b1; we = 1'b0; addr = a; be = 4'h0;
        sb.push_back(exp);
        tick();
        cs = 1'b0;
        e = sb.pop_front();
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk(tag, rdata, e);
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; we = 1'b0; be = 4'h0;
        addr = '0; wdata = '0; gpio_in = '0;
        tick();
        tick();
        chk("rst_out", gpio_out, 32'h0);
        chk("rst_oe", gpio_oe, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        reset_n = 1'b1;
        rd("rst_r_out", 12'h000, 32'h0);
        rd("rst_r_dir", 12'h004, 32'h0);
        rd("rst_r_in", 12'h008, 32'h0);
        rd("rst_r_ien", 12'h00C, 32'h0);
        rd("rst_r_stat", 12'h010, 32'h0);

        wr(12'h000, 32'hA5A5_5A5A, 4'b0011);
        rd("out_lo", 12'h000, 32'h0000_5A5A);
        chk("pin_out_lo", gpio_out, 32'h0000_5A5A);
        wr(12'h000, 32'hA5A5_5A5A, 4'b1100);
        rd("out_full", 12'h000, 32'hA5A5_5A5A);
        wr(12'h004, 32'h1234_FFFF, 4'b1111);
        chk("pin_oe", gpio_oe, 32'h1234_FFFF);
        rd("dir", 12'h004, 32'h1234_FFFF);
        chk("out_dir_indep", gpio_out, 32'hA5A5_5A5A);
        wr(12'h014, 32'hFFFF_FFFF, 4'b1111);
        rd("unmapped_wr", 12'h000, 32'hA5A5_5A5A);

        wr(12'h00C, 32'h0000_0001, 4'b1111);
        gpio_in = 32'h1;
        rd("in_lat1", 12'h008, 32'h0);
        rd("in_lat2", 12'h008, 32'h0);
        rd("in_lat3", 12'h008, 32'h1);
        rd("stat_set", 12'h010, 32'h1);
        chk("irq_set", {31'd0, irq}, 32'd1);

        gpio_in = 32'h0;
        wr(12'h010, 32'h1, 4'b1111);
        tick();
        tick();
        tick();
        rd("stat_clr", 12'h010, 32'h0);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        gpio_in = 32'h1;
        tick();
        tick();
        wr(12'h010, 32'h1, 4'b1111);
        rd("stat_set_wins", 12'h010, 32'h1);
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_hold", {31'd0, irq}, 32'd1);

        wr(12'h00C, 32'h0, 4'b1111);
        chk("irq_lag", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_gated", {31'd0, irq}, 32'd0);
        rd("stat_no_ien", 12'h010, 32'h1);

        rd("in_read", 12'h008, 32'h1);
        tick();
        chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);
        chk("rdata_hold", rdata, 32'h1);
        rd("unmapped_rd", 12'h014, 32'h0);
        wr(12'h008, 32'hFFFF_FFFE, 4'b1111);
        rd("in_ro", 12'h008, 32'h1);

        wr(12'h00C, 32'hF, 4'b1111);
        gpio_in = 32'h0;
        cs = 1'b1; we = 1'b0; addr = 12'h000;
        reset_n = 1'b0;
        tick();
        cs = 1'b0;
        chk("rst_drop_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        chk("rst2_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst2_out", gpio_out, 32'h0);
        chk("rst2_oe", gpio_oe, 32'h0);
        chk("rst2_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        rd("rst2_r_ien", 12'h00C, 32'h0);
        rd("rst2_r_stat", 12'h010, 32'h0);
        rd("rst2_r_out", 12'h000, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
